// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO and models multi-cycle latency with a countdown.
// Optional MADD/MADDU accumulate support is enabled by defining MDU_MADD_EN.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUCtrl,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      pendHi_r;
    logic [31:0]      pendLo_r;
    logic             pendWr_r;

    logic signed [63:0] prodS_s;
    logic [63:0]        prodU_s;
    logic [31:0]        absA_s, absB_s, divisorS_s, divisorU_s;
    logic [31:0]        uqS_s, urS_s, quoS_s, remS_s, quoU_s, remU_s;
    logic               divZero_s;

    logic        isMul_s, isDiv_s, isMthi_s, isMtlo_s;
    logic [63:0] opResult_s;

    assign prodS_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
    assign prodU_s = {32'd0, srcA} * {32'd0, srcB};

    // Signed divide via magnitudes so the 0x80000000 / -1 case wraps cleanly to 0x80000000 rem 0
    assign absA_s     = srcA[31] ? (32'd0 - srcA) : srcA;
    assign absB_s     = srcB[31] ? (32'd0 - srcB) : srcB;
    assign divZero_s  = (srcB == 32'd0);
    assign divisorS_s = divZero_s ? 32'd1 : absB_s;
    assign divisorU_s = divZero_s ? 32'd1 : srcB;
    assign uqS_s      = absA_s / divisorS_s;
    assign urS_s      = absA_s % divisorS_s;
    assign quoS_s     = (srcA[31] ^ srcB[31]) ? (32'd0 - uqS_s) : uqS_s;
    assign remS_s     = srcA[31] ? (32'd0 - urS_s) : urS_s;
    assign quoU_s     = srcA / divisorU_s;
    assign remU_s     = srcA % divisorU_s;

`ifdef MDU_MADD_EN
    logic [63:0] accS_s, accU_s;
    assign accS_s = {HI, LO} + prodS_s;
    assign accU_s = {HI, LO} + prodU_s;
`endif

    // Operation decode and selection of the 64-bit {HI,LO} result
    always_comb begin
        isMul_s    = 1'b0;
        isDiv_s    = 1'b0;
        isMthi_s   = 1'b0;
        isMtlo_s   = 1'b0;
        opResult_s = 64'd0;
        case (MDUCtrl)
            4'd1: begin isMul_s = 1'b1; opResult_s = prodS_s; end
            4'd2: begin isMul_s = 1'b1; opResult_s = prodU_s; end
            4'd3: begin isDiv_s = 1'b1; opResult_s = {remS_s, quoS_s}; end
            4'd4: begin isDiv_s = 1'b1; opResult_s = {remU_s, quoU_s}; end
            4'd5: isMthi_s = 1'b1;
            4'd6: isMtlo_s = 1'b1;
`ifdef MDU_MADD_EN
            4'd7: begin isMul_s = 1'b1; opResult_s = accS_s; end
            4'd8: begin isMul_s = 1'b1; opResult_s = accU_s; end
`endif
            default: opResult_s = 64'd0;
        endcase
    end

    // Sequencer: issue in IDLE, count down in RUN, commit pending result on the last cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            pendHi_r <= 32'd0;
            pendLo_r <= 32'd0;
            pendWr_r <= 1'b0;
            busy     <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && (isMul_s || isDiv_s)) begin
                        pendHi_r <= opResult_s[63:32];
                        pendLo_r <= opResult_s[31:0];
                        pendWr_r <= !(isDiv_s && divZero_s);
                        cnt_r    <= isDiv_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else if (start && isMthi_s) begin
                        HI <= srcA;
                    end else if (start && isMtlo_s) begin
                        LO <= srcA;
                    end
                end
                RUN: begin
                    if (cnt_r == CNT_W'(1)) begin
                        if (pendWr_r) begin
                            HI <= pendHi_r;
                            LO <= pendLo_r;
                        end
                        cnt_r   <= {CNT_W{1'b0}};
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: table of directed vectors plus hand-written reset/MT/RUN sequences.
module tb_mdu_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  MDUCtrl = 4'd0;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] preHi;
        logic [31:0] preLo;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUCtrl(MDUCtrl),
        .srcA(srcA), .srcB(srcB), .busy(busy), .HI(HI), .LO(LO)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; MDUCtrl = c; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0; MDUCtrl = 4'd0;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic addVec(input string nm, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ph, input logic [31:0] pl,
                          input logic [31:0] eh, input logic [31:0] el, input int cy);
        vec_t v;
        v.name = nm; v.ctrl = c; v.a = a; v.b = b; v.preHi = ph; v.preLo = pl;
        v.expHi = eh; v.expLo = el; v.cyc = cy;
        vecs.push_back(v);
    endtask

    initial begin
        int n;

        addVec("mult_neg1x2",  4'd1, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, MC);
        addVec("multu_neg1x2", 4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE, MC);
        addVec("mult_m1xm1",   4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000000, 32'h00000001, MC);
        addVec("multu_maxsq",  4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, MC);
        addVec("mult_3x4",     4'd1, 32'd3, 32'd4, 32'h55, 32'h66, 32'h00000000, 32'h0000000C, MC);
        addVec("div_m7_2",     4'd3, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC);
        addVec("div_m7_m2",    4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000003, DC);
        addVec("div_7_m2",     4'd3, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, DC);
        addVec("divu_7_2",     4'd4, 32'd7, 32'd2, 32'h0, 32'h0, 32'h00000001, 32'h00000003, DC);
        addVec("divu_max_16",  4'd4, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0, 32'h0000000F, 32'h0FFFFFFF, DC);
        addVec("div_ovf",      4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000000, 32'h80000000, DC);
        addVec("div_by_zero",  4'd3, 32'd5, 32'd0, 32'h11, 32'h22, 32'h00000011, 32'h00000022, DC);
        addVec("divu_by_zero", 4'd4, 32'd9, 32'd0, 32'h33, 32'h44, 32'h00000033, 32'h00000044, DC);
        addVec("mthi",         4'd5, 32'hDEADBEEF, 32'd0, 32'h1, 32'h2, 32'hDEADBEEF, 32'h00000002, 0);
        addVec("ctrl_none",    4'd0, 32'd3, 32'd4, 32'h7, 32'h8, 32'h00000007, 32'h00000008, 0);
        addVec("ctrl_illegal", 4'd9, 32'd3, 32'd4, 32'h9, 32'hA, 32'h00000009, 32'h0000000A, 0);
`ifdef MDU_MADD_EN
        addVec("maddu_1x1",    4'd8, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, MC);
        addVec("madd_m1x2",    4'd7, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h5, 32'h00000000, 32'h00000003, MC);
        addVec("madd_wrap",    4'd7, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, MC);
`else
        addVec("maddu_1x1",    4'd8, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0);
        addVec("madd_m1x2",    4'd7, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h5, 32'h00000000, 32'h00000005, 0);
`endif

        // Power-on reset
        #2 reset = 1'b0;
        #2;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            issue(4'd5, vecs[i].preHi, 32'd0);
            issue(4'd6, vecs[i].preLo, 32'd0);
            issue(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            waitIdle(n);
            chk({vecs[i].name, " busy cycles"}, 32'(n), 32'(vecs[i].cyc));
            chk({vecs[i].name, " HI"}, HI, vecs[i].expHi);
            chk({vecs[i].name, " LO"}, LO, vecs[i].expLo);
        end

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1; MDUCtrl = 4'd5; srcA = 32'hDEADBEEF;
        @(negedge clk);
        chk("mt seq busy1", {31'd0, busy}, 32'd0);
        chk("mt seq HI", HI, 32'hDEADBEEF);
        MDUCtrl = 4'd6; srcA = 32'h12345678;
        @(negedge clk);
        start = 1'b0; MDUCtrl = 4'd0;
        chk("mt seq busy2", {31'd0, busy}, 32'd0);
        chk("mt seq LO", LO, 32'h12345678);
        chk("mt seq HI kept", HI, 32'hDEADBEEF);

        // MTLO while RUN must be ignored
        issue(4'd1, 32'd3, 32'd4);
        @(negedge clk);
        start = 1'b1; MDUCtrl = 4'd6; srcA = 32'hFFFF0000;
        @(negedge clk);
        start = 1'b0; MDUCtrl = 4'd0;
        chk("run mtlo LO held", LO, 32'h12345678);
        chk("run mtlo busy", {31'd0, busy}, 32'd1);
        waitIdle(n);
        chk("run mtlo cycles", 32'(n + 2), 32'(MC));
        chk("run mtlo HI", HI, 32'd0);
        chk("run mtlo LO", LO, 32'd12);

        // Asynchronous reset in the middle of a MULT
        issue(4'd5, 32'hAAAA5555, 32'd0);
        issue(4'd1, 32'd3, 32'd4);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrun reset busy", {31'd0, busy}, 32'd0);
        chk("midrun reset HI", HI, 32'd0);
        chk("midrun reset LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("post reset busy", {31'd0, busy}, 32'd0);
        chk("post reset HI", HI, 32'd0);
        chk("post reset LO", LO, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
